// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: requester source ids and the memory arbiter grant-state encoding.
package mycpu_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arbState_e;

endpackage

// File: rtl/arb_order_fifo.sv
// Ordering FIFO for the memory arbiter: remembers which requester owns each
// accepted-but-unanswered transaction so in-order responses can be routed back.
module arb_order_fifo
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pushSrc,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_src;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;

  // DEPTH is a power of two, so pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + 1'b1;
      if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_src[r_wrPtr] <= pushSrc;
  end

  // Count equals DEPTH exactly when its top bit is set.
  assign full  = r_count[PW];
  assign empty = (r_count == '0);
  assign head  = r_src[r_rdPtr];

endmodule

// File: rtl/sram_arb.sv
// Two-master sram-like arbiter (instruction fetch vs data access) onto one memory port.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_arb
  import mycpu_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arbState_e r_state;
  logic      w_idlePickData;
  logic      w_grantData;
  logic      w_grantReq;
  logic      w_selData;
  logic      w_accept;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  logic      w_head;

`ifdef SRAM_ARB_RR_EN
  logic r_rrPrefData;

  assign w_idlePickData = data_req & (~inst_req | r_rrPrefData);

  // The requester granted last loses priority on the next contention.
  always_ff @(posedge clk) begin
    if (reset)         r_rrPrefData <= 1'b1;
    else if (w_accept) r_rrPrefData <= ~w_selData;
  end
`else
  assign w_idlePickData = data_req;
`endif

  always_comb begin
    w_grantData = w_idlePickData;
    case (r_state)
      ARB_HOLD_I: w_grantData = 1'b0;
      ARB_HOLD_D: w_grantData = 1'b1;
      default:    w_grantData = w_idlePickData;
    endcase
  end

  // Reset forces the inst mux so the downstream fields stay deterministic.
  assign w_selData  = ~reset & w_grantData;
  assign w_grantReq = w_selData ? data_req : inst_req;

  assign mem_req   = ~reset & ~w_full & w_grantReq;
  assign mem_wr    = w_selData ? data_wr    : inst_wr;
  assign mem_size  = w_selData ? data_size  : inst_size;
  assign mem_wstrb = w_selData ? data_wstrb : inst_wstrb;
  assign mem_addr  = w_selData ? data_addr  : inst_addr;
  assign mem_wdata = w_selData ? data_wdata : inst_wdata;

  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & ~w_selData;
  assign data_addr_ok = w_accept &  w_selData;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (mem_req && !mem_addr_ok)
            r_state <= w_grantData ? ARB_HOLD_D : ARB_HOLD_I;
        end
        ARB_HOLD_I, ARB_HOLD_D: begin
          if (w_accept) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // A response with nothing outstanding is dropped rather than routed.
  assign w_pop = ~reset & mem_data_ok & ~w_empty;

  arb_order_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_orderFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (w_accept),
    .pushSrc(w_selData),
    .pop    (w_pop),
    .full   (w_full),
    .empty  (w_empty),
    .head   (w_head)
  );

  assign inst_data_ok = w_pop & (w_head == SRC_INST);
  assign data_data_ok = w_pop & (w_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-master arbiter that shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data-access requester (EXE/MEM stages). Sits between `mycpu_top`'s pipeline and the unified memory/bridge port. Grants one address phase per cycle, holds the grant until the address is accepted, and routes in-order read/write responses back to the originating requester via an ordering FIFO.

## Interface
Parameters:
- `OUTSTANDING`, 2, max accepted-but-unanswered transactions (power of two, 2..8)

Ports (prefix `inst_` / `data_` / `mem_`; requester sides are identical):
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `{inst,data}_req`  in  1  request valid; held with fields stable until `_addr_ok`
- `{inst,data}_wr`  in  1  1 = write
- `{inst,data}_size`  in  2  0/1/2 = byte/half/word
- `{inst,data}_wstrb`  in  4  byte strobes
- `{inst,data}_addr`  in  32  address
- `{inst,data}_wdata`  in  32  write data
- `{inst,data}_addr_ok`  out  1  address phase accepted this cycle
- `{inst,data}_data_ok`  out  1  response for oldest outstanding transaction of this requester
- `{inst,data}_rdata`  out  32  read data, valid with `_data_ok`
- `mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata`  out  1/1/2/4/32/32  downstream request
- `mem_addr_ok`  in  1  downstream accepted address phase
- `mem_data_ok`  in  1  downstream response (in order)
- `mem_rdata`  in  32  downstream read data

## Operation
- Grant FSM states: IDLE, HOLD_I, HOLD_D.
  - IDLE: pick winner among asserted reqs; drive its fields on `mem_*`. If `mem_addr_ok` same cycle → stay IDLE; else → HOLD_I/HOLD_D.
  - HOLD_x: grant locked to x regardless of other req; on `mem_addr_ok` → IDLE.
- Accept = `mem_req & mem_addr_ok`; only granted requester sees `_addr_ok`=1.
- `mem_req` = 0 when ordering FIFO full (count == OUTSTANDING); no accept, FSM state unchanged.
- On accept, push source id (0 inst, 1 data) into ordering FIFO.
- On `mem_data_ok` with FIFO non-empty: pop head, assert that source's `_data_ok`; `mem_rdata` drives both `_rdata` buses.
- Push and pop same cycle: count unchanged, both pointers advance; legal when full (pop frees slot next cycle only; `mem_req` still gated that cycle).
- `mem_data_ok` with FIFO empty: ignored, no `_data_ok`; verification asserts it never occurs.
- Pointers wrap modulo OUTSTANDING; count width clog2(OUTSTANDING)+1.

## Timing
- All request/response paths combinational: `_req`→`mem_req` 0 cycles; `mem_addr_ok`→`_addr_ok` 0 cycles; `mem_data_ok`→`_data_ok` 0 cycles.
- FSM, FIFO, pointers, count, round-robin pointer register on `clk`.
- Reset (synchronous, any cycle, including mid-HOLD or with outstanding entries): state IDLE, count 0, pointers 0, rr pointer = data-preferred. While `reset`=1 all outputs 0 (`mem_req`, all `_addr_ok`, `_data_ok`; `_rdata`/`mem_*` fields don't-care but driven from inst mux). Outstanding transactions are dropped; downstream must be reset concurrently.
- Requester dropping `req` before `_addr_ok` is a protocol violation (asserted in bench).

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin in IDLE — requester granted last loses priority next time both request; rr pointer updates on accept only.
- Undefined: fixed priority, data always beats inst in IDLE. rr register not built.

## Structure
- Shared package `mycpu_pkg`: `SRC_INST`=1'b0, `SRC_DATA`=1'b1, FSM state encoding `ARB_IDLE/ARB_HOLD_I/ARB_HOLD_D`.
- Sub-module `arb_order_fifo` (1-bit wide, depth OUTSTANDING, push/pop/full/empty/head); top holds FSM and muxes.

## Test plan
- Inst req addr 0x1c000000, `mem_addr_ok`=1 same cycle, `mem_data_ok` 2 cycles later with rdata 0x02800c0c → `inst_addr_ok` cycle 0, `inst_data_ok`+rdata 0x02800c0c cycle 2, `data_data_ok` stays 0.
- Both req same cycle, fixed priority → data granted, inst waits; with `SRAM_ARB_RR_EN`, two back-to-back contentions grant data then inst.
- Inst req, `mem_addr_ok`=0 for 3 cycles, data req arrives cycle 1 → grant stays inst (HOLD_I), `mem_addr`=inst addr until accept, then data granted.
- OUTSTANDING=2: accept inst, data, then third req → `mem_req`=0 until first `mem_data_ok`; responses route inst then data.
- Push and pop same cycle at count 1 → count stays 1, correct routing of both.
- Reset asserted with 2 outstanding in HOLD_D → next cycle all outputs 0, count 0, state IDLE; stray `mem_data_ok` produces no `_data_ok`.
